// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED bank arbiter and related board arbiters.
package led_arb_pkg;

    // Arbiter FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_OVR  = 2'd2
    } state_t;

    // Width of the LED bank and each requester's pattern
    localparam int LED_W  = 8;
    // Switch bit that enables the manual override
    localparam int SW_OVR = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap,
// optionally skipping one index (used to pre-empt the current owner).
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [IW-1:0] mask_idx,
    input  logic          mask_en,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam int unsigned NU = N;

    int unsigned cand;

    // First eligible request after ptr; ptr itself is considered last
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int unsigned off = 1; off <= NU; off++) begin
            cand = (32'(ptr) + off) % NU;
            if (!valid && req[cand[IW-1:0]] && !(mask_en && (cand == 32'(mask_idx)))) begin
                valid                 = 1'b1;
                idx                   = cand[IW-1:0];
                onehot[cand[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// LED bank arbiter: round-robin ownership of the 8-bit LED bank with a
// minimum hold time, bounded maximum hold (pre-emption), and a switch override.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MIN_HOLD = 16,
    parameter int MAX_HOLD = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] data,
    input  logic [7:0]             sw,
    output logic [N_REQ-1:0]       grant,
    output logic [LED_W-1:0]       led,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] MIN_C   = CW'(MIN_HOLD);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_HOLD);
    localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [LED_W-1:0] owner_led;
    logic             release_ok;
    logic             preempt;

    // While owning, the owner (== ptr) is excluded so pick_valid means "someone else waits"
    rr_pick #(.N(N_REQ)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .mask_idx (ptr),
        .mask_en  (state == ST_OWN),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // Select the current owner's LED pattern
    always_comb begin
        owner_led = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ptr == IW'(i)) owner_led = data[i*LED_W +: LED_W];
        end
    end

    // Release and pre-emption conditions for the current owner
    always_comb begin
        release_ok = !req[ptr] && (cnt >= MIN_C);
        preempt    = (cnt == MAX_C) && pick_valid;
    end

    // Arbiter FSM with hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            grant <= '0;
            led   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            ptr   <= PTR_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sw[SW_OVR]) begin
                        state <= ST_OVR;
                    end else if (pick_valid) begin
                        grant <= pick_onehot;
                        ptr   <= pick_idx;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    led <= owner_led;
                    if (sw[SW_OVR]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_OVR;
                    end else if (release_ok || preempt) begin
                        if (pick_valid) begin
                            grant <= pick_onehot;
                            ptr   <= pick_idx;
                            cnt   <= '0;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (cnt != MAX_C) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_OVR: begin
                    led   <= {1'b0, sw[SW_OVR-1:0]};
                    grant <= '0;
                    busy  <= 1'b0;
                    if (!sw[SW_OVR]) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
